// File: rtl/md_wrapper_core.sv
// ---------------------------------------------------------------------------
// md_lane_add: one axis of the position update (p + v), 32-bit wrapping add.
//   a, b : addends (position, velocity)
//   y    : a + b modulo 2^W
// ---------------------------------------------------------------------------
module md_lane_add #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = a + b;
endmodule

// ---------------------------------------------------------------------------
// md_wrapper_core: particle store with an explicit-Euler position integrator.
//   LOAD    : elem_write streams d_in[191:0] into the store (up to DEPTH).
//   COMPUTE : step passes over the store, one entry per cycle, p += v.
//   READY   : each read_ctrl rising edge returns the next entry on d_out
//             with a one-cycle elem_read strobe; the pointer wraps at count.
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   d_in[209:0]         record {tag, vz, vy, vx, pz, py, px}; tag ignored
//   elem_write          write strobe (level, one record per cycle)
//   step[31:0]          iteration count, sampled when LOAD ends
//   read_ctrl           read request, rising-edge sensitive
//   d_out[191:0]        returned record {vz, vy, vx, pz, py, px}
//   elem_read           one-cycle valid for d_out
// ---------------------------------------------------------------------------
module md_wrapper_core #(
   parameter int DEPTH = 512
) (
   input  logic         ap_clk,
   input  logic         ap_rst,
   input  logic [209:0] d_in,
   input  logic         elem_write,
   input  logic [31:0]  step,
   input  logic         read_ctrl,
   output logic [191:0] d_out,
   output logic         elem_read
);
   localparam int NUM_LANES = 3;
   localparam int VEC_W     = 32;
   localparam int REC_W     = 2 * NUM_LANES * VEC_W;
   localparam int AW        = $clog2(DEPTH);
   localparam int CW        = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {LOAD, COMPUTE, READY} state_t;

   state_t                           state;
   logic [CW-1:0]                    count;
   logic [AW-1:0]                    idx;
   logic [AW-1:0]                    rd_ptr;
   logic [31:0]                      iter;
   logic                             we_q;
   logic                             rc_q;

   logic [REC_W-1:0]                 mem [DEPTH];
   logic [REC_W-1:0]                 cur_rec;
   logic [NUM_LANES-1:0][VEC_W-1:0]  pos, vel, pos_nxt;

   logic                             mem_we;
   logic [AW-1:0]                    mem_waddr;
   logic [REC_W-1:0]                 mem_wdata;

   logic                             last_idx;
   logic                             last_rd;

   // Compute path: read entry idx, add velocity per lane, write back same cycle.
   assign cur_rec = mem[idx];
   assign pos     = cur_rec[NUM_LANES*VEC_W-1:0];
   assign vel     = cur_rec[REC_W-1:NUM_LANES*VEC_W];

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      md_lane_add #(.W(VEC_W)) u_add (
         .a (pos[g]),
         .b (vel[g]),
         .y (pos_nxt[g])
      );
   end

   assign last_idx = (CW'(idx) + CW'(1)) == count;
   assign last_rd  = (CW'(rd_ptr) + CW'(1)) == count;

   // Single write port shared by loading, the integrator and the READY reload.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = d_in[REC_W-1:0];
      if (!ap_rst) begin
         case (state)
            LOAD: begin
               if (elem_write && count < DEPTH_C) begin
                  mem_we    = 1'b1;
                  mem_waddr = count[AW-1:0];
               end
            end
            COMPUTE: begin
               mem_we    = 1'b1;
               mem_waddr = idx;
               mem_wdata = {vel, pos_nxt};
            end
            READY: begin
               // A write in READY restarts loading at entry 0.
               if (elem_write) mem_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Store contents are not reset; only written entries are ever read.
   always_ff @(posedge ap_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= LOAD;
         count     <= '0;
         idx       <= '0;
         rd_ptr    <= '0;
         iter      <= '0;
         we_q      <= 1'b0;
         rc_q      <= 1'b0;
         d_out     <= '0;
         elem_read <= 1'b0;
      end else begin
         we_q      <= elem_write;
         rc_q      <= read_ctrl;
         elem_read <= 1'b0;
         case (state)
            LOAD: begin
               if (elem_write) begin
                  if (count < DEPTH_C) count <= count + CW'(1);
               end else if (we_q && count != '0) begin
                  // Falling edge of elem_write ends the load phase.
                  iter   <= step;
                  idx    <= '0;
                  rd_ptr <= '0;
                  state  <= (step == 32'd0) ? READY : COMPUTE;
               end
            end
            COMPUTE: begin
               if (last_idx) begin
                  idx <= '0;
                  if (iter <= 32'd1) begin
                     iter   <= '0;
                     rd_ptr <= '0;
                     state  <= READY;
                  end else begin
                     iter <= iter - 32'd1;
                  end
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            READY: begin
               // Reload wins over a coincident read edge.
               if (elem_write) begin
                  count <= CW'(1);
                  state <= LOAD;
               end else if (read_ctrl && !rc_q) begin
                  d_out     <= mem[rd_ptr];
                  elem_read <= 1'b1;
                  rd_ptr    <= last_rd ? '0 : rd_ptr + AW'(1);
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_md_wrapper_core.sv
module tb_md_wrapper_core;
   localparam int DEPTH = 16;

   logic         ap_clk = 1'b0;
   logic         ap_rst;
   logic [209:0] d_in;
   logic         elem_write;
   logic [31:0]  step;
   logic         read_ctrl;
   logic [191:0] d_out;
   logic         elem_read;

   int checks = 0;
   int errors = 0;

   logic [191:0] stim[$];
   logic [191:0] mdl[$];
   int           mdl_ptr;

   md_wrapper_core #(.DEPTH(DEPTH)) dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .d_in       (d_in),
      .elem_write (elem_write),
      .step       (step),
      .read_ctrl  (read_ctrl),
      .d_out      (d_out),
      .elem_read  (elem_read)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic logic [191:0] mk(input logic [31:0] px, py, pz, vx, vy, vz);
      return {vz, vy, vx, pz, py, px};
   endfunction

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Stream stim[] into the DUT, build the expected store, optionally wait out compute.
   task automatic load_and_run(input logic [31:0] stp, input bit wait_done);
      logic [191:0] r;
      elem_write = 1'b1;
      foreach (stim[i]) begin
         d_in = {18'($urandom), stim[i]};
         tick();
      end
      elem_write = 1'b0;
      step       = stp;
      d_in       = '0;
      mdl.delete();
      for (int i = 0; i < stim.size() && i < DEPTH; i++) mdl.push_back(stim[i]);
      mdl_ptr = 0;
      if (wait_done) begin
         for (int s = 0; s < int'(stp); s++)
            foreach (mdl[k]) begin
               r = mdl[k];
               for (int a = 0; a < 3; a++) r[32*a +: 32] = r[32*a +: 32] + r[96 + 32*a +: 32];
               mdl[k] = r;
            end
         repeat (mdl.size() * int'(stp) + 4) tick();
      end
   endtask

   // One read request held for `hold` cycles; counts elem_read strobes seen.
   task automatic do_read(input int hold, output logic [191:0] data, output int pulses);
      data      = 'x;
      pulses    = 0;
      read_ctrl = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (elem_read) begin pulses++; data = d_out; end
      end
      read_ctrl = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (elem_read) begin pulses++; data = d_out; end
      end
   endtask

   task automatic test_reset();
      logic [191:0] data;
      int           p;
      ap_rst = 1'b1; elem_write = 1'b0; read_ctrl = 1'b0; step = '0; d_in = '0;
      tick(); tick();
      checks++;
      if (d_out !== 192'd0) begin errors++; $display("FAIL reset_d_out: got %h expected 0", d_out); end
      checks++;
      if (elem_read !== 1'b0) begin errors++; $display("FAIL reset_elem_read: got %b expected 0", elem_read); end
      ap_rst = 1'b0;
      tick();
      do_read(2, data, p);
      checks++;
      if (p != 0) begin errors++; $display("FAIL read_in_load: got %0d pulses expected 0", p); end
   endtask

   task automatic test_step0();
      logic [191:0] data;
      logic [191:0] exp_q[$];
      int           p;
      stim = '{mk(1,2,3,10,20,30), mk(5,5,5,0,0,0), mk(0,0,0,1,1,1)};
      exp_q = stim;
      load_and_run(0, 1);
      for (int i = 0; i < 3; i++) begin
         do_read(2, data, p);
         checks++;
         if (p != 1) begin errors++; $display("FAIL step0_pulses[%0d]: got %0d expected 1", i, p); end
         checks++;
         if (data !== exp_q[i]) begin errors++; $display("FAIL step0_data[%0d]: got %h expected %h", i, data, exp_q[i]); end
      end
   endtask

   task automatic test_step2();
      logic [191:0] data;
      logic [191:0] exp_q[$];
      int           p;
      stim = '{mk(1,2,3,10,20,30), mk(5,5,5,0,0,0), mk(0,0,0,1,1,1)};
      exp_q = '{mk(21,42,63,10,20,30), mk(5,5,5,0,0,0), mk(2,2,2,1,1,1)};
      load_and_run(2, 1);
      for (int i = 0; i < 3; i++) begin
         do_read(2, data, p);
         checks++;
         if (p != 1) begin errors++; $display("FAIL step2_pulses[%0d]: got %0d expected 1", i, p); end
         checks++;
         if (data !== exp_q[i]) begin errors++; $display("FAIL step2_data[%0d]: got %h expected %h", i, data, exp_q[i]); end
      end
   endtask

   task automatic test_overflow_wrap();
      logic [191:0] data;
      int           p;
      stim = '{mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 7, 1, 1, 32'hFFFF_FFFE)};
      load_and_run(1, 1);
      do_read(2, data, p);
      checks++;
      if (data[31:0] !== 32'h8000_0000) begin errors++; $display("FAIL wrap_px: got %h expected 80000000", data[31:0]); end
      checks++;
      if (data !== mk(32'h8000_0000, 0, 5, 1, 1, 32'hFFFF_FFFE)) begin
         errors++; $display("FAIL wrap_rec: got %h expected %h", data, mk(32'h8000_0000, 0, 5, 1, 1, 32'hFFFF_FFFE));
      end
   endtask

   task automatic test_read_held();
      logic [191:0] data;
      int           p;
      stim = '{mk(1,2,3,10,20,30), mk(5,5,5,0,0,0), mk(0,0,0,1,1,1)};
      load_and_run(0, 1);
      do_read(32, data, p);
      checks++;
      if (p != 1) begin errors++; $display("FAIL held_pulses: got %0d expected 1", p); end
      checks++;
      if (data !== stim[0]) begin errors++; $display("FAIL held_data: got %h expected %h", data, stim[0]); end
      do_read(2, data, p);
      do_read(2, data, p);
      do_read(2, data, p);
      checks++;
      if (data !== stim[0]) begin errors++; $display("FAIL ptr_wrap: got %h expected %h", data, stim[0]); end
   endtask

   task automatic test_random();
      logic [191:0] data;
      int           p, n;
      logic [31:0]  stp;
      for (int t = 0; t < 5; t++) begin
         n   = $urandom_range(1, 8);
         stp = $urandom_range(0, 4);
         stim.delete();
         for (int i = 0; i < n; i++)
            stim.push_back(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
         load_and_run(stp, 1);
         for (int r = 0; r <= n; r++) begin
            do_read(2, data, p);
            checks++;
            if (p != 1 || data !== mdl[mdl_ptr]) begin
               errors++;
               $display("FAIL rand[%0d.%0d]: got %h pulses %0d expected %h", t, r, data, p, mdl[mdl_ptr]);
            end
            mdl_ptr = (mdl_ptr + 1) % mdl.size();
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [191:0] data;
      int           p;
      stim = '{mk(1,2,3,10,20,30), mk(5,5,5,0,0,0), mk(0,0,0,1,1,1)};
      load_and_run(1000, 0);
      tick();
      do_read(2, data, p);
      checks++;
      if (p != 0) begin errors++; $display("FAIL read_in_compute: got %0d pulses expected 0", p); end
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      checks++;
      if (d_out !== 192'd0) begin errors++; $display("FAIL midrst_d_out: got %h expected 0", d_out); end
      checks++;
      if (elem_read !== 1'b0) begin errors++; $display("FAIL midrst_elem_read: got %b expected 0", elem_read); end
      for (int i = 0; i < 3; i++) begin
         do_read(2, data, p);
         checks++;
         if (p != 0) begin errors++; $display("FAIL read_after_rst[%0d]: got %0d pulses expected 0", i, p); end
      end
      load_and_run(0, 1);
      do_read(2, data, p);
      checks++;
      if (p != 1 || data !== stim[0]) begin
         errors++; $display("FAIL reload_after_rst: got %h pulses %0d expected %h", data, p, stim[0]);
      end
   endtask

   task automatic test_depth();
      logic [191:0] data;
      int           p;
      stim.delete();
      for (int i = 0; i < DEPTH + 5; i++)
         stim.push_back(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
      load_and_run(1, 1);
      for (int r = 0; r <= DEPTH; r++) begin
         do_read(2, data, p);
         checks++;
         if (p != 1 || data !== mdl[mdl_ptr]) begin
            errors++;
            $display("FAIL depth[%0d]: got %h pulses %0d expected %h", r, data, p, mdl[mdl_ptr]);
         end
         mdl_ptr = (mdl_ptr + 1) % mdl.size();
      end
   endtask

   initial begin
      test_reset();
      test_step0();
      test_step2();
      test_overflow_wrap();
      test_read_held();
      test_random();
      test_reset_mid();
      test_depth();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/md_wrapper_core.md
MD_WRAPPER_CORE -- requirements
Module: md_wrapper

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; all state is updated on the rising edge of ap_clk.
REQ-002 Port: ap_clk  input  1  system clock.
REQ-003 Port: ap_rst  input  1  synchronous active-high reset.
REQ-004 Port: d_in  input  210  particle record; [31:0] px, [63:32] py, [95:64] pz, [127:96] vx, [159:128] vy, [191:160] vz, [209:192] tag (ignored).
REQ-005 Port: elem_write  input  1  level; each cycle high writes d_in into the particle store.
REQ-006 Port: step  input  32  number of integration iterations; sampled at compute start.
REQ-007 Port: read_ctrl  input  1  read request; rising edge requests the next particle.
REQ-008 Port: d_out  output  192  particle record, same layout as d_in[191:0].
REQ-009 Port: elem_read  output  1  one-cycle pulse; d_out valid in that cycle.
REQ-010 Parameter: DEPTH, default 512, particle store capacity (entries).

Function
REQ-011 SHALL implement states LOAD, COMPUTE, READY.
- LOAD: each cycle with elem_write=1 and count<DEPTH, store d_in[191:0] at index count; count++.
- count==DEPTH: further writes SHALL be dropped; count stays DEPTH.
REQ-012 SHALL leave LOAD on the cycle after elem_write falls (1->0) with count>0.
- Enters COMPUTE and latches step into an iteration counter.
- If the latched step is 0, SHALL enter READY directly.
REQ-013 COMPUTE SHALL process one entry per cycle, indices 0..count-1, per iteration.
- Each entry: px+=vx, py+=vy, pz+=vz.
- 32-bit two's-complement adds; wrap on overflow; no saturation.
- Velocities unchanged.
REQ-014 COMPUTE SHALL repeat REQ-013 once per latched step iteration, then enter READY.
- Total COMPUTE duration: count*step cycles (+/-1 cycle of state transition).
REQ-015 Entering READY SHALL clear the read pointer to 0.
REQ-016 In READY, a read_ctrl rising edge (read_ctrl=1, previous-cycle sample=0) SHALL, within 2 cycles:
- drive d_out with entry[read pointer];
- pulse elem_read for exactly one cycle;
- increment the read pointer.
REQ-017 read_ctrl held high SHALL produce one read only; a new rising edge is needed for the next.
REQ-018 The read pointer SHALL wrap from count-1 to 0.
REQ-019 d_out SHALL hold its last value between reads.
REQ-020 read_ctrl edges in LOAD or COMPUTE SHALL be ignored; elem_read stays 0.
REQ-021 elem_write=1 in READY SHALL clear count to 0 and return to LOAD.
- That cycle's d_in is stored as entry 0.
REQ-022 elem_write=1 during COMPUTE SHALL be ignored.
REQ-023 Read edge and state transition in the same cycle: the transition takes priority; the edge is discarded.

Reset
REQ-024 ap_rst=1 SHALL, on the next clock edge, force:
- state=LOAD, count=0, read pointer=0, iteration counter=0;
- d_out=0, elem_read=0, edge-detect register=0.
REQ-025 Reset SHALL apply mid-operation (LOAD/COMPUTE/READY) and abort any compute in progress.
REQ-026 After reset, store contents SHALL be treated as invalid; only reads of written entries are defined.

Verification
REQ-027 Load 3 records with step=0 (p=(1,2,3), v=(10,20,30); p=(5,5,5), v=(0,0,0); p=(0,0,0), v=(1,1,1)), drop elem_write, then 3 read_ctrl pulses -> 3 elem_read pulses; d_out equals the inputs in order.
REQ-028 Same load with step=2 -> reads return p=(21,42,63), (5,5,5), (2,2,2); velocities unchanged.
REQ-029 px=0x7FFFFFFF, vx=1, step=1 -> read px=0x80000000 (wrap).
REQ-030 read_ctrl held high 32 cycles, then low -> exactly one elem_read; a 4th pulse after 3 entries returns entry 0.
REQ-031 Assert ap_rst during COMPUTE -> next cycle d_out=0 and elem_read=0; read_ctrl pulses give no elem_read until a new load completes.
REQ-032 elem_write held for DEPTH+5 cycles -> count=DEPTH; extra writes dropped; DEPTH reads return the first DEPTH records.
